// File: rtl/riscv_pc_ctrl_if.sv
// Fetch-side bundle of the PC controller: imem handshake, decode hand-off,
// redirect input and the shared next-PC adder operands/result.
interface riscv_pc_ctrl_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] o_pc;
    logic            o_imem_req;
    logic            i_imem_gnt;
    logic            i_imem_rvalid;
    logic            o_if_valid;
    logic [XLEN-1:0] o_if_pc;
    logic            i_stall;
    logic            i_redirect;
    logic [XLEN-1:0] i_redirect_target;
    logic            o_misalign;
    logic [XLEN-1:0] o_adder_a;
    logic [XLEN-1:0] o_adder_b;
    logic [XLEN-1:0] i_adder_sum;

    modport master (
        output o_pc, o_imem_req, o_if_valid, o_if_pc, o_misalign, o_adder_a, o_adder_b,
        input  i_imem_gnt, i_imem_rvalid, i_stall, i_redirect, i_redirect_target, i_adder_sum
    );

    modport slave (
        input  o_pc, o_imem_req, o_if_valid, o_if_pc, o_misalign, o_adder_a, o_adder_b,
        output i_imem_gnt, i_imem_rvalid, i_stall, i_redirect, i_redirect_target, i_adder_sum
    );
endinterface

// File: rtl/riscv_pc_ctrl.sv
// RV32I fetch-stage PC controller: sequences single-outstanding imem fetches,
// holds on decode stalls and applies branch/jump redirects with stale-response drain.
module riscv_pc_ctrl #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    riscv_pc_ctrl_if.master   bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pc_s;
    logic            misalign_r;
    logic            misalign_s;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

    // State, PC and misalign flag registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r    <= ST_IDLE;
            pc_r       <= RESET_VEC;
            misalign_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            misalign_r <= misalign_s;
        end
    end

    // Next-state and next-PC selection; a redirect overrides stall and sequential advance.
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        misalign_s = 1'b0;
        if (bus.i_redirect) begin
            pc_s       = align_word(bus.i_redirect_target);
            misalign_s = |bus.i_redirect_target[1:0];
            case (state_r)
                // A grant this cycle still belongs to the old PC, so its response must be dropped.
                ST_REQ:   state_s = bus.i_imem_gnt    ? ST_DRAIN : ST_REQ;
                ST_WAIT:  state_s = bus.i_imem_rvalid ? ST_REQ   : ST_DRAIN;
                ST_DRAIN: state_s = bus.i_imem_rvalid ? ST_REQ   : ST_DRAIN;
                ST_IDLE:  state_s = ST_REQ;
                ST_HOLD:  state_s = ST_REQ;
                default:  state_s = ST_IDLE;
            endcase
        end else begin
            case (state_r)
                ST_IDLE: state_s = ST_REQ;
                ST_REQ: begin
                    if (bus.i_imem_gnt) begin
                        state_s = ST_WAIT;
                    end else begin
                        state_s = ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (bus.i_imem_rvalid && !bus.i_stall) begin
                        pc_s    = bus.i_adder_sum;
                        state_s = ST_REQ;
                    end else if (bus.i_imem_rvalid) begin
                        state_s = ST_HOLD;
                    end else begin
                        state_s = ST_WAIT;
                    end
                end
                ST_HOLD: begin
                    if (!bus.i_stall) begin
                        pc_s    = bus.i_adder_sum;
                        state_s = ST_REQ;
                    end else begin
                        state_s = ST_HOLD;
                    end
                end
                ST_DRAIN: begin
                    if (bus.i_imem_rvalid) begin
                        state_s = ST_REQ;
                    end else begin
                        state_s = ST_DRAIN;
                    end
                end
                default: state_s = ST_IDLE;
            endcase
        end
    end

    assign bus.o_pc       = pc_r;
    assign bus.o_if_pc    = pc_r;
    assign bus.o_misalign = misalign_r;
    assign bus.o_imem_req = (state_r == ST_REQ);
    assign bus.o_if_valid = (state_r == ST_WAIT) && bus.i_imem_rvalid && !bus.i_redirect;
    assign bus.o_adder_a  = pc_r;
    assign bus.o_adder_b  = {{(XLEN-3){1'b0}}, 3'b100};

endmodule

// File: doc/riscv_pc_ctrl.md
Name: riscv_pc_ctrl

Overview:
Fetch-stage PC controller for the RV32I core. Holds the architectural fetch PC and drives the shared next-PC adder (operands PC and 4). Sequences instruction-memory requests with a req/gnt/rvalid handshake and handles pipeline stalls. Applies redirects from branch/jump resolution, discarding any in-flight fetch.

Parameters:
XLEN, 32, datapath width; PC arithmetic is modulo 2^XLEN
RESET_VEC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned

Ports:
i_clk  in  1  core clock, rising edge
i_rst  in  1  asynchronous, active-high reset
o_pc  out  XLEN  current fetch address, registered; also imem address
o_imem_req  out  1  fetch request valid
i_imem_gnt  in  1  imem accepted the request this cycle
i_imem_rvalid  in  1  instruction data for the granted request is returned this cycle
o_if_valid  out  1  fetched instruction is valid for decode (1-cycle pulse)
o_if_pc  out  XLEN  PC of the instruction flagged by o_if_valid
i_stall  in  1  decode cannot accept a new instruction
i_redirect  in  1  branch taken or jump; load i_redirect_target
i_redirect_target  in  XLEN  redirect destination
o_misalign  out  1  registered 1-cycle pulse: redirect target had [1:0]!=0
o_adder_a  out  XLEN  adder operand A (= o_pc)
o_adder_b  out  XLEN  adder operand B (constant 4)
i_adder_sum  in  XLEN  adder result, used as sequential next PC

Behaviour:
- Reset (async, on i_rst high): o_pc=RESET_VEC; state=IDLE; o_misalign=0. Consequently o_imem_req=0 and o_if_valid=0. o_if_pc equals o_pc.
- Interface decode: o_imem_req = (state==REQ). o_if_valid = (state==WAIT) & i_imem_rvalid & ~i_redirect. o_if_pc = o_pc. o_adder_a = o_pc; o_adder_b = 4.
- States: IDLE, REQ, WAIT, HOLD, DRAIN; 3-bit encoding; unused encodings go to IDLE.
- IDLE: next cycle REQ. First request is issued 1 cycle after reset release.
- REQ: o_pc is held until granted.
  - i_imem_gnt -> WAIT.
  - No grant -> stay in REQ.
- WAIT: outstanding request; o_pc is the address being fetched.
  - On i_imem_rvalid & ~i_stall: o_pc <= i_adder_sum; -> REQ.
  - On i_imem_rvalid & i_stall: o_pc unchanged; -> HOLD. The instruction is still presented via o_if_valid this cycle; decode latches it.
  - Without rvalid: stay in WAIT.
- HOLD: stay while i_stall=1. When i_stall=0: o_pc <= i_adder_sum; -> REQ.
- DRAIN: discard the stale outstanding response.
  - On i_imem_rvalid: -> REQ; o_if_valid stays 0.
  - Otherwise stay in DRAIN.
- Redirect has priority over stall and the sequential update. In any state, when i_redirect=1: o_pc <= {i_redirect_target[XLEN-1:2],2'b00}; o_misalign <= |i_redirect_target[1:0]. Next state:
  - REQ & i_imem_gnt -> DRAIN: granted with old PC.
  - REQ & ~i_imem_gnt -> REQ: address changes before grant, which is legal.
  - WAIT & i_imem_rvalid -> REQ: response dropped.
  - WAIT & ~i_imem_rvalid -> DRAIN.
  - DRAIN & i_imem_rvalid -> REQ.
  - DRAIN & ~i_imem_rvalid -> DRAIN, with the PC updated.
  - IDLE or HOLD -> REQ.
- o_misalign is 0 in every cycle that does not follow a misaligned redirect.
- At most one outstanding request. i_imem_rvalid outside WAIT/DRAIN is ignored.
- Wrap: o_pc=FFFF_FFFC advances to 0000_0000 with no flag.
- Latency: back-to-back fetch with gnt in REQ and rvalid the next cycle gives one instruction every 2 cycles.

Test Plan:
- Reset with RESET_VEC=0x100, gnt=1, rvalid=1 one cycle after each grant -> o_imem_req rises 1 cycle after reset release; o_if_valid with o_if_pc 0x100, 0x104, 0x108 on alternate cycles.
- i_stall=1 for 3 cycles starting at the rvalid of 0x104 -> o_if_valid pulses once for 0x104; o_pc holds 0x104 and req=0 while stalled; next request is 0x108.
- Redirect to 0x200 in WAIT without rvalid, rvalid arrives 2 cycles later -> DRAIN; stale data produces no o_if_valid; next request is 0x200.
- Redirect to 0x302 together with rvalid in WAIT -> o_if_valid=0; o_pc=0x300; o_misalign pulses 1 cycle; next request is 0x300.
- i_imem_gnt=0 for 4 cycles, redirect to 0x400 during the wait -> o_imem_req stays 1 and the address switches to 0x400; after grant and rvalid, o_if_pc=0x400.
- Redirect to 0xFFFF_FFFC, then sequential fetch -> second fetch address 0x0000_0000; assert i_rst mid-WAIT -> req=0, o_pc=RESET_VEC immediately.
